// File: rtl/alu_packet_responder_if.sv
// Byte-wide AXI-stream channel used on both sides of the ALU packet responder.
interface alu_packet_responder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/alu_packet_responder.sv
// Device-side endpoint of the UART ALU protocol: parses command packets from
// the rx stream and answers with echo data or a 32-bit ALU result.
// Optional feature macro: ALU_MUL_EN (adds the shift-add MUL opcode).
module alu_packet_responder #(
    parameter logic [7:0] OPCODE_ECHO_P = 8'hEC,
    parameter logic [7:0] OPCODE_ADD_P  = 8'hA0,
    parameter logic [7:0] OPCODE_MUL_P  = 8'hB0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    alu_packet_responder_if.slave         s_axis,
    alu_packet_responder_if.master        m_axis,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam logic [3:0] S_OPC    = 4'd0;
    localparam logic [3:0] S_RSVD   = 4'd1;
    localparam logic [3:0] S_LEN_LO = 4'd2;
    localparam logic [3:0] S_LEN_HI = 4'd3;
    localparam logic [3:0] S_ECHO   = 4'd4;
    localparam logic [3:0] S_OPND   = 4'd5;
    localparam logic [3:0] S_RESP   = 4'd6;
    localparam logic [3:0] S_DRAIN  = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] S_MUL    = 4'd8;
    localparam bit         MUL_EN   = 1'b1;
`else
    localparam bit         MUL_EN   = 1'b0;
`endif

    logic [3:0]  state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [23:0] word_q, word_d;     // first three bytes of the operand in flight
    logic [1:0]  bcnt_q, bcnt_d;
    logic        first_q, first_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  rcnt_q, rcnt_d;
    logic        err_q, err_d;
`ifdef ALU_MUL_EN
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [4:0]  mcnt_q, mcnt_d;
`endif

    logic        s_hs, m_hs;
    logic [15:0] len_w, rem_w;
    logic [31:0] word_w;
    logic        is_echo, is_mul, is_alu;

    assign s_hs    = s_axis.tvalid && s_axis.tready;
    assign m_hs    = m_axis.tvalid && m_axis.tready;
    assign len_w   = {s_axis.tdata, len_lo_q};
    assign rem_w   = len_w - 16'd4;
    assign word_w  = {s_axis.tdata, word_q};
    assign is_echo = (op_q == OPCODE_ECHO_P);
    assign is_mul  = MUL_EN && (op_q == OPCODE_MUL_P);
    assign is_alu  = (op_q == OPCODE_ADD_P) || is_mul;
    assign busy_o  = (state_q != S_OPC);
    assign err_o   = err_q;

    // Stream-side outputs; held at reset values while rst_n is low.
    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 8'h00;
        if (rst_n) begin
            case (state_q)
                S_OPC, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPND, S_DRAIN:
                    s_axis.tready = 1'b1;
                S_ECHO: begin
                    m_axis.tdata  = s_axis.tdata;
                    m_axis.tvalid = s_axis.tvalid;
                    s_axis.tready = m_axis.tready;
                end
                S_RESP: begin
                    m_axis.tvalid = 1'b1;
                    m_axis.tdata  = acc_q[8*rcnt_q +: 8];
                end
                default: ;
            endcase
        end
    end

    // Packet parser / ALU next-state logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        first_d  = first_q;
        acc_d    = acc_q;
        rcnt_d   = rcnt_q;
        err_d    = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mcnt_d   = mcnt_q;
`endif
        case (state_q)
            S_OPC: if (s_hs) begin
                op_d    = s_axis.tdata;
                state_d = S_RSVD;
            end
            S_RSVD: if (s_hs) state_d = S_LEN_LO;
            S_LEN_LO: if (s_hs) begin
                len_lo_d = s_axis.tdata;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (s_hs) begin
                rem_d   = rem_w;
                bcnt_d  = 2'd0;
                first_d = 1'b1;
                acc_d   = 32'd0;
                if (len_w < 16'd4) begin
                    err_d   = 1'b1;
                    rem_d   = 16'd0;
                    state_d = S_OPC;
                end else if (is_echo) begin
                    state_d = (rem_w == 16'd0) ? S_OPC : S_ECHO;
                end else if (is_alu && len_w >= 16'd8 && len_w[1:0] == 2'b00) begin
                    state_d = S_OPND;
                end else begin
                    err_d   = 1'b1;
                    state_d = (rem_w == 16'd0) ? S_OPC : S_DRAIN;
                end
            end
            S_ECHO, S_DRAIN: if (s_hs) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_OPC;
            end
            S_OPND: if (s_hs) begin
                rem_d  = rem_q - 16'd1;
                word_d = word_w[31:8];
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        acc_d   = word_w;
                        state_d = (rem_q == 16'd1) ? S_RESP : S_OPND;
`ifdef ALU_MUL_EN
                    end else if (is_mul) begin
                        mcand_d  = acc_q;
                        mplier_d = word_w;
                        prod_d   = 32'd0;
                        mcnt_d   = 5'd0;
                        state_d  = S_MUL;
`endif
                    end else begin
                        acc_d   = acc_q + word_w;
                        state_d = (rem_q == 16'd1) ? S_RESP : S_OPND;
                    end
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q + 5'd1;
                if (mcnt_q == 5'd31) begin
                    acc_d   = prod_d;
                    state_d = (rem_q == 16'd0) ? S_RESP : S_OPND;
                end
            end
`endif
            S_RESP: if (m_hs) begin
                rcnt_d = rcnt_q + 2'd1;
                if (rcnt_q == 2'd3) begin
                    state_d = S_OPC;
                    acc_d   = 32'd0;
                end
            end
            default: state_d = S_OPC;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_OPC;
            op_q     <= 8'h00;
            len_lo_q <= 8'h00;
            rem_q    <= 16'd0;
            word_q   <= 24'd0;
            bcnt_q   <= 2'd0;
            first_q  <= 1'b0;
            acc_q    <= 32'd0;
            rcnt_q   <= 2'd0;
            err_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 32'd0;
            mcnt_q   <= 5'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            word_q   <= word_d;
            bcnt_q   <= bcnt_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            rcnt_q   <= rcnt_d;
            err_q    <= err_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            mcnt_q   <= mcnt_d;
`endif
        end
    end

endmodule

// File: doc/alu_packet_responder.md
Name: alu_packet_responder

Overview:
- Device-side endpoint of the host-to-board UART ALU protocol.
- Consumes bytes from the UART receiver's AXI-stream output, parses command packets, and executes echo or 32-bit ALU operations.
- Emits response bytes into the UART transmitter's AXI-stream input.
- Sits between the uart rx/tx core and nothing else in the icebreaker top, in the PLL clock domain.

Parameters:
- OPCODE_ECHO_P, 8'hEC, opcode that returns the payload unchanged.
- OPCODE_ADD_P, 8'hA0, opcode for the 32-bit sum of all operands.
- OPCODE_MUL_P, 8'hB0, opcode for the 32-bit product of all operands (only with the optional feature).

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  8  received byte from the uart rx
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  responder accepts the byte
- m_axis_tdata  out  8  response byte to the uart tx
- m_axis_tvalid  out  1  response byte valid
- m_axis_tready  in  1  uart tx accepts the byte
- busy_o  out  1  high whenever the FSM is not in OPC
- err_o  out  1  one-cycle pulse on a malformed or unknown packet

Behaviour:
- Packet format:
  - Byte 0: opcode. Byte 1: reserved, ignored.
  - Bytes 2–3: total length L, little-endian, header included.
  - Payload: L-4 bytes. ALU operands are 32-bit little-endian words.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a clk edge.
  - m_axis_tdata/m_axis_tvalid stay stable while tvalid=1 and tready=0.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, err_o=0, FSM=OPC, accumulator=0, counter=0.
- Reset asserted mid-packet aborts the packet; no partial response is emitted after reset is released.
- FSM states: OPC, RSVD, LEN_LO, LEN_HI, ECHO, OPND, MUL, RESP, DRAIN.
- Header states:
  - OPC/RSVD/LEN_LO/LEN_HI: s_axis_tready=1; each accepted byte advances one state.
  - LEN_HI computes rem = L-4 (16-bit) and checks the packet.
- Packet checks at the LEN_HI handshake:
  - L<4: err_o pulse, go to OPC.
  - Unknown opcode: err_o pulse; rem>0 goes to DRAIN, otherwise OPC.
  - ALU opcode with L<8 or L[1:0]!=0: err_o pulse, then DRAIN (or OPC if rem=0).
  - Echo with rem=0: go to OPC, no output.
- ECHO (pass-through, zero added latency):
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - Decrement rem per transfer; go to OPC when the last byte transfers.
- OPND:
  - s_axis_tready=1. Shift bytes into a 32-bit word register, LSB first.
  - On the 4th byte, the first word loads the accumulator. Later words: ADD does acc<=acc+word (mod 2^32); MUL enters the MUL state.
  - After the last word (rem reaches 0, including any MUL cycles): go to RESP.
- RESP:
  - s_axis_tready=0. Emit acc[7:0], [15:8], [23:16], [31:24] in order, each held until accepted.
  - m_axis_tvalid asserts the cycle after entry to RESP.
  - After the 4th handshake: go to OPC, acc=0.
- DRAIN: s_axis_tready=1; discard rem bytes, then go to OPC.
- err_o never asserts simultaneously with m_axis_tvalid.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - OPCODE_MUL_P is valid.
  - Each operand after the first runs a 32-cycle shift-add multiply in state MUL: acc<=acc*word mod 2^32.
  - s_axis_tready=0 while in MUL.
  - Total response latency grows by 32 cycles per extra operand.
- Undefined: OPCODE_MUL_P is treated as an unknown opcode (err_o pulse plus DRAIN); no MUL state or multiplier logic exists.

Test Plan:
- Echo: send EC 00 07 00 41 42 43 with m_axis_tready=1 -> output 41 42 43 with zero cycles between s and m handshakes; busy_o low afterwards; err_o never high.
- ADD: send A0 00 0C 00 FF FF FF FF 02 00 00 00 -> response 01 00 00 00 (wrap-around); next packet accepted normally.
- Backpressure: ADD with m_axis_tready held low for 20 cycles during RESP -> first byte stays valid and stable; all 4 bytes in order once ready rises.
- Errors:
  - Opcode 0x55 with L=6 -> single err_o pulse, 2 payload bytes drained, no output.
  - ADD with L=0x000A -> err_o pulse, 6 bytes drained, no output.
- MUL (ALU_MUL_EN defined): send B0 00 10 00 03 00 00 00 05 00 00 00 07 00 00 00 -> response 69 00 00 00. Without the macro: err_o pulse, no output.
- Reset: rst_n driven low after byte 6 of an ADD packet -> outputs return to reset values; after release, a fresh echo packet works correctly.
